channel_scheduler: RTL and testbench
====================================

CHANNEL_SCHEDULER -- requirements
Module: channel_scheduler

Interface
REQ-001 Parameter: BURST, 4, maximum consecutive cycles one channel keeps its grant (legal range 1..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: arb_en  input  1  arbitration enable; low suppresses and releases all grants.
REQ-005 Port: req  input  4  per-channel request, bit i = channel i.
REQ-006 Port: sel  output  2  granted channel index; drives the downstream 2-to-4 decoder select input.
REQ-007 Port: sel_en  output  1  grant valid; drives the downstream decoder enable input.
REQ-008 Port: gnt_new  output  1  one-cycle pulse in the first cycle of every new grant.

Function
REQ-009 The block SHALL register sel, sel_en and gnt_new; no combinational path SHALL exist from inputs to outputs.
REQ-010 The block SHALL implement two states: IDLE (sel_en=0) and GRANT (sel_en=1).
REQ-011 The block SHALL keep a 2-bit pointer last_ch holding the most recently released channel.
REQ-012 Search order SHALL be last_ch+1, last_ch+2, last_ch+3, last_ch (mod 4); the first channel in that order with req=1 wins.
REQ-013 In IDLE, when arb_en=1 and req!=0 at a rising edge, the block SHALL enter GRANT with sel=winner, sel_en=1, gnt_new=1, burst counter=1 (one-cycle latency).
REQ-014 In GRANT, the block SHALL hold sel and increment the counter each edge while req[sel]=1, arb_en=1 and counter<BURST.
REQ-015 In GRANT, release SHALL occur at the edge where req[sel]=0, or counter==BURST, or arb_en=0; on release last_ch SHALL load sel.
REQ-016 On release with arb_en=1 and req!=0, the block SHALL grant the next winner at the same edge, searching from the updated last_ch. There SHALL be no idle cycle, gnt_new SHALL be 1 and the counter SHALL be 1.
REQ-017 A still-requesting channel that hit BURST SHALL be re-granted only if no other channel requests; in that case gnt_new SHALL pulse again.
REQ-018 On release with arb_en=0 or req=0, the block SHALL return to IDLE with sel_en=0.
REQ-019 When sel_en=0, sel SHALL hold its last value.
REQ-020 gnt_new SHALL be 0 in every cycle other than the first cycle of a grant.
REQ-021 The counter SHALL be 8 bits wide and SHALL never exceed BURST; with BURST=1 every grant SHALL last exactly one cycle.
REQ-022 Request changes on non-granted channels during GRANT SHALL NOT affect the current grant.

Reset
REQ-023 rst_n=0 SHALL immediately and asynchronously set: state=IDLE, sel=2'b00, sel_en=0, gnt_new=0, counter=0, last_ch=2'b11 (so channel 0 has first priority).
REQ-024 Reset asserted mid-grant SHALL drop sel_en without waiting for a clock edge.
REQ-025 After rst_n rises, the first grant SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-026 Single request: after reset, arb_en=1, req=4'b0001 -> next cycle sel=0, sel_en=1, gnt_new=1; following cycle gnt_new=0, sel_en stays 1; with BURST=4 the block re-grants channel 0 every 4 cycles with a gnt_new pulse.
REQ-027 Full load: BURST=4, req=4'b1111 held -> sel runs 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0..., sel_en constantly 1, gnt_new=1 on each index change.
REQ-028 Early drop: only req[2]=1 granted, req[2] deasserted after 2 grant cycles -> sel_en=0 next cycle, sel stays 2, last_ch=2.
REQ-029 Wrap-around: last_ch=3, req=4'b1001 -> grant channel 0; on its release, channel 3 is granted back-to-back with gnt_new=1.
REQ-030 Enable gating: arb_en deasserted mid-grant of channel 1 with req=4'b1111 -> sel_en=0 next cycle. arb_en reasserted -> channel 2 granted one cycle later.
REQ-031 Reset mid-grant: rst_n pulsed low while sel=2, sel_en=1 -> sel_en=0 and sel=0 immediately. With req=4'b1111 after release, channel 0 is granted first.

Source files
------------

// File: rtl/channel_scheduler.sv
// Round-robin grant scheduler for four channels with a per-grant burst limit.
// Drives the select/enable inputs of a downstream 2-to-4 decoder from registers.
module channel_scheduler #(
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arb_en,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic       sel_en,
  output logic       gnt_new
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_ch_q, last_ch_d;
  logic [7:0] cnt_q, cnt_d;
  logic       gnt_new_q, gnt_new_d;

  // Search starts one past base and ends on base itself, so base has lowest priority.
  function automatic logic [1:0] pick(input logic [1:0] base, input logic [3:0] r);
    logic [1:0] c;
    pick = base;
    for (int k = 4; k >= 1; k--) begin
      c = base + 2'(k);
      if (r[c]) pick = c;
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_ch_d = last_ch_q;
    cnt_d     = cnt_q;
    gnt_new_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_en && (req != 4'b0000)) begin
          state_d   = GRANT;
          sel_d     = pick(last_ch_q, req);
          cnt_d     = 8'd1;
          gnt_new_d = 1'b1;
        end
      end
      GRANT: begin
        if (req[sel_q] && arb_en && (cnt_q < 8'(BURST))) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          // Released channel becomes the lowest-priority candidate for the next grant.
          last_ch_d = sel_q;
          if (arb_en && (req != 4'b0000)) begin
            sel_d     = pick(sel_q, req);
            cnt_d     = 8'd1;
            gnt_new_d = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 2'b00;
      last_ch_q <= 2'b11;
      cnt_q     <= 8'd0;
      gnt_new_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_ch_q <= last_ch_d;
      cnt_q     <= cnt_d;
      gnt_new_q <= gnt_new_d;
    end
  end

  assign sel     = sel_q;
  assign sel_en  = (state_q == GRANT);
  assign gnt_new = gnt_new_q;

endmodule

// File: tb/tb_channel_scheduler.sv
// Table-driven bench for channel_scheduler with a queue-based scoreboard;
// a second instance with BURST=1 is checked in the post-reset sequence.
module tb_channel_scheduler;

  logic       clk;
  logic       rst_n;
  logic       arb_en;
  logic [3:0] req;
  logic [1:0] sel, sel_b1;
  logic       sel_en, sel_en_b1;
  logic       gnt_new, gnt_new_b1;

  channel_scheduler #(.BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req),
    .sel(sel), .sel_en(sel_en), .gnt_new(gnt_new)
  );

  channel_scheduler #(.BURST(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req),
    .sel(sel_b1), .sel_en(sel_en_b1), .gnt_new(gnt_new_b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       arb;
    logic [3:0] rq;
    logic [1:0] esel;
    logic       een;
    logic       egnt;
  } vec_t;

  typedef struct packed {
    logic [3:0] exp_main;
    logic       chk_b1;
    logic [3:0] exp_b1;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  step_no = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got sel/en/gnt=%b required %b", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue expectations, and compare after the edge.
  task automatic step(input logic a, input logic [3:0] r, input logic [3:0] exp_m,
                      input logic cb1, input logic [3:0] exp_b);
    sb_t e;
    arb_en = a;
    req    = r;
    sb_q.push_back({exp_m, cb1, exp_b});
    @(posedge clk);
    #1;
    step_no++;
    e = sb_q.pop_front();
    check($sformatf("step%0d", step_no), {sel, sel_en, gnt_new}, e.exp_main);
    if (e.chk_b1)
      check($sformatf("step%0d_b1", step_no), {sel_b1, sel_en_b1, gnt_new_b1}, e.exp_b1);
    $display("step %0d arb=%b req=%b -> sel=%0d en=%b gnt=%b", step_no, a, r, sel, sel_en, gnt_new);
  endtask

  vec_t vecs[41];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit hit, required finish earlier");
    $fatal(1, "timeout");
  end

  initial begin
    vecs = '{
      '{1'b1, 4'b0001, 2'd0, 1'b1, 1'b1},  // single request, first grant
      '{1'b1, 4'b0001, 2'd0, 1'b1, 1'b0},
      '{1'b1, 4'b0001, 2'd0, 1'b1, 1'b0},
      '{1'b1, 4'b0001, 2'd0, 1'b1, 1'b0},
      '{1'b1, 4'b0001, 2'd0, 1'b1, 1'b1},  // burst limit, re-grant same channel
      '{1'b1, 4'b0001, 2'd0, 1'b1, 1'b0},
      '{1'b1, 4'b0000, 2'd0, 1'b0, 1'b0},
      '{1'b1, 4'b1111, 2'd1, 1'b1, 1'b1},  // full load rotation
      '{1'b1, 4'b1111, 2'd1, 1'b1, 1'b0},
      '{1'b1, 4'b1111, 2'd1, 1'b1, 1'b0},
      '{1'b1, 4'b1111, 2'd1, 1'b1, 1'b0},
      '{1'b1, 4'b1111, 2'd2, 1'b1, 1'b1},
      '{1'b1, 4'b1111, 2'd2, 1'b1, 1'b0},
      '{1'b1, 4'b1111, 2'd2, 1'b1, 1'b0},
      '{1'b1, 4'b1111, 2'd2, 1'b1, 1'b0},
      '{1'b1, 4'b1111, 2'd3, 1'b1, 1'b1},
      '{1'b1, 4'b1111, 2'd3, 1'b1, 1'b0},
      '{1'b1, 4'b1111, 2'd3, 1'b1, 1'b0},
      '{1'b1, 4'b1111, 2'd3, 1'b1, 1'b0},
      '{1'b1, 4'b1111, 2'd0, 1'b1, 1'b1},
      '{1'b1, 4'b1111, 2'd0, 1'b1, 1'b0},
      '{1'b1, 4'b0100, 2'd2, 1'b1, 1'b1},  // early drop on channel 2
      '{1'b1, 4'b0100, 2'd2, 1'b1, 1'b0},
      '{1'b1, 4'b0000, 2'd2, 1'b0, 1'b0},
      '{1'b1, 4'b0000, 2'd2, 1'b0, 1'b0},
      '{1'b1, 4'b1000, 2'd3, 1'b1, 1'b1},  // wrap-around setup
      '{1'b1, 4'b0000, 2'd3, 1'b0, 1'b0},
      '{1'b1, 4'b1001, 2'd0, 1'b1, 1'b1},
      '{1'b1, 4'b1001, 2'd0, 1'b1, 1'b0},
      '{1'b1, 4'b1000, 2'd3, 1'b1, 1'b1},
      '{1'b1, 4'b1000, 2'd3, 1'b1, 1'b0},
      '{1'b1, 4'b0010, 2'd1, 1'b1, 1'b1},  // enable gating on channel 1
      '{1'b1, 4'b1111, 2'd1, 1'b1, 1'b0},
      '{1'b0, 4'b1111, 2'd1, 1'b0, 1'b0},
      '{1'b0, 4'b1111, 2'd1, 1'b0, 1'b0},
      '{1'b1, 4'b1111, 2'd2, 1'b1, 1'b1},
      '{1'b1, 4'b1111, 2'd2, 1'b1, 1'b0},
      '{1'b1, 4'b0100, 2'd2, 1'b1, 1'b0},  // other channels toggle mid-grant
      '{1'b1, 4'b0111, 2'd2, 1'b1, 1'b0},
      '{1'b1, 4'b0111, 2'd0, 1'b1, 1'b1},
      '{1'b1, 4'b0100, 2'd2, 1'b1, 1'b1}
    };

    rst_n  = 1'b0;
    arb_en = 1'b0;
    req    = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {sel, sel_en, gnt_new}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 41; i++)
      step(vecs[i].arb, vecs[i].rq, {vecs[i].esel, vecs[i].een, vecs[i].egnt}, 1'b0, 4'b0000);

    // Asynchronous reset mid-grant of channel 2.
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", {sel, sel_en, gnt_new}, 4'b0000);
    arb_en = 1'b1;
    req    = 4'b1111;
    @(posedge clk);
    #1;
    check("no_grant_in_reset", {sel, sel_en, gnt_new}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 4'b1111, {2'd0, 1'b1, 1'b1}, 1'b1, {2'd0, 1'b1, 1'b1});
    step(1'b1, 4'b1111, {2'd0, 1'b1, 1'b0}, 1'b1, {2'd1, 1'b1, 1'b1});
    step(1'b1, 4'b0001, {2'd0, 1'b1, 1'b0}, 1'b1, {2'd0, 1'b1, 1'b1});
    step(1'b1, 4'b0001, {2'd0, 1'b1, 1'b0}, 1'b1, {2'd0, 1'b1, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
